enemy_render_ctrl: RTL and testbench

Control-side partner of an enemy datapath. Issues the `update_enemy` request and consumes the `done_update_enemy` pulse. Around each position update it erases the enemy's previously drawn box and draws the box at the new position, driving the VGA adapter's pixel-plot port one pixel per clock. One instance sits beside each enemy datapath; plot ports are muxed to the adapter upstream.

---
 rtl/game_pkg.sv | 27 ++
 rtl/enemy_render_ctrl_if.sv | 33 +++
 rtl/box_scanner.sv | 60 ++++++
 rtl/enemy_render_ctrl.sv | 131 +++++++++++++
 tb/tb_enemy_render_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared screen geometry, bus widths and controller state codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int CNT_W    = 4;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_REQ   = 3'd2,
        ST_ERASE = 3'd3,
        ST_LATCH = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/enemy_render_ctrl_if.sv
// ============================================================================
// Module      : enemy_render_ctrl_if
// Description : Datapath handshake and VGA pixel-plot signals of one enemy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface enemy_render_ctrl_if;
    import game_pkg::*;

    logic                update_enemy;
    logic                done_update_enemy;
    logic [X_W-1:0]      enemy_x;
    logic [Y_W-1:0]      enemy_y;
    logic [COLOUR_W-1:0] enemy_colour;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                plot;

    modport master (
        output update_enemy, vga_x, vga_y, vga_colour, plot,
        input  done_update_enemy, enemy_x, enemy_y, enemy_colour
    );

    modport slave (
        input  update_enemy, vga_x, vga_y, vga_colour, plot,
        output done_update_enemy, enemy_x, enemy_y, enemy_colour
    );

endinterface

`default_nettype wire

// File: rtl/box_scanner.sv
// ============================================================================
// Module      : box_scanner
// Description : Row-major dx/dy raster counter over a BOX_W x BOX_H sprite.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module box_scanner
    import game_pkg::*;
#(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    output logic [CNT_W-1:0] dx,
    output logic [CNT_W-1:0] dy,
    output logic             busy,
    output logic             last
);

    localparam logic [CNT_W-1:0] C_DX_MAX = CNT_W'(BOX_W - 1);
    localparam logic [CNT_W-1:0] C_DY_MAX = CNT_W'(BOX_H - 1);

    logic [CNT_W-1:0] r_dx;
    logic [CNT_W-1:0] r_dy;
    logic             w_row_end;

    assign w_row_end = (r_dx == C_DX_MAX);
    assign last      = w_row_end && (r_dy == C_DY_MAX);
    assign busy      = (r_dx != '0) || (r_dy != '0);
    assign dx        = r_dx;
    assign dy        = r_dy;

    // The final step wraps to (0,0) so the next raster starts clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (start) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (step) begin
            if (last) begin
                r_dx <= '0;
                r_dy <= '0;
            end else if (w_row_end) begin
                r_dx <= '0;
                r_dy <= r_dy + 1'b1;
            end else begin
                r_dx <= r_dx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/enemy_render_ctrl.sv
// ============================================================================
// Module      : enemy_render_ctrl
// Description : Erase/redraw sequencer and update handshake for one enemy box.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_render_ctrl
    import game_pkg::*;
#(
    parameter int                  BOX_W     = 4,
    parameter int                  BOX_H     = 4,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                space_pressed,
    enemy_render_ctrl_if.master bus
);

    state_t              r_state;
    state_t              w_next;
    logic                r_space_d;
    logic                w_space_evt;
    logic [X_W-1:0]      r_old_x;
    logic [Y_W-1:0]      r_old_y;
    logic                r_update;
    logic                r_plot;
    logic [X_W-1:0]      r_vga_x;
    logic [Y_W-1:0]      r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;

    logic                w_scan_start;
    logic                w_scan_step;
    logic [CNT_W-1:0]    w_dx;
    logic [CNT_W-1:0]    w_dy;
    logic                w_scan_busy;
    logic                w_scan_last;

    logic [X_W:0]        w_px;
    logic [Y_W:0]        w_py;
    logic                w_clip;
    logic                w_rastering;

    box_scanner #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H)
    ) u_box_scanner (
        .clk   (clk),
        .reset (reset),
        .start (w_scan_start),
        .step  (w_scan_step),
        .dx    (w_dx),
        .dy    (w_dy),
        .busy  (w_scan_busy),
        .last  (w_scan_last)
    );

    // A held restart key counts once: only its rising edge acts.
    assign w_space_evt = space_pressed && !r_space_d;

    // Wide sums so an overhanging box clips instead of wrapping to column 0.
    assign w_px        = {1'b0, r_old_x} + {{(X_W + 1 - CNT_W){1'b0}}, w_dx};
    assign w_py        = {1'b0, r_old_y} + {{(Y_W + 1 - CNT_W){1'b0}}, w_dy};
    assign w_clip      = (w_px > (X_W + 1)'(SCREEN_W - 1)) || (w_py > (Y_W + 1)'(SCREEN_H - 1));
    assign w_rastering = (r_state == ST_DRAW) || (r_state == ST_ERASE);

    always_comb begin
        w_next       = r_state;
        w_scan_start = 1'b0;
        w_scan_step  = 1'b0;
        case (r_state)
            ST_INIT: w_next = ST_DRAW;
            ST_DRAW: begin
                if (w_space_evt) begin
                    w_next       = ST_ERASE;
                    w_scan_start = w_scan_busy;
                end else begin
                    w_scan_step = 1'b1;
                    if (w_scan_last) w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_space_evt || bus.done_update_enemy) w_next = ST_ERASE;
            end
            ST_ERASE: begin
                w_scan_step = 1'b1;
                if (w_scan_last) w_next = ST_LATCH;
            end
            ST_LATCH: w_next = w_space_evt ? ST_ERASE : ST_DRAW;
            default:  w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_INIT;
            r_space_d    <= 1'b0;
            r_old_x      <= '0;
            r_old_y      <= '0;
            r_update     <= 1'b0;
            r_plot       <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
        end else begin
            r_state   <= w_next;
            r_space_d <= space_pressed;
            r_update  <= (w_next == ST_REQ);
            r_plot    <= w_rastering && !w_clip;
            if ((r_state == ST_INIT) || (r_state == ST_LATCH)) begin
                r_old_x <= bus.enemy_x;
                r_old_y <= bus.enemy_y;
            end
            if (w_rastering) begin
                r_vga_x      <= w_px[X_W-1:0];
                r_vga_y      <= w_py[Y_W-1:0];
                r_vga_colour <= (r_state == ST_DRAW) ? bus.enemy_colour : BG_COLOUR;
            end
        end
    end

    assign bus.update_enemy = r_update;
    assign bus.plot         = r_plot;
    assign bus.vga_x        = r_vga_x;
    assign bus.vga_y        = r_vga_y;
    assign bus.vga_colour   = r_vga_colour;

endmodule

`default_nettype wire

// File: tb/tb_enemy_render_ctrl.sv
// ============================================================================
// Module      : tb_enemy_render_ctrl
// Description : Directed self-checking bench for enemy_render_ctrl (4x4 box).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_render_ctrl;

    localparam int BW = 4;
    localparam int BH = 4;

    logic clk;
    logic reset;
    logic space_pressed;
    int   n_checks;
    int   n_fail;
    int   n;

    enemy_render_ctrl_if bus();

    enemy_render_ctrl #(
        .BOX_W     (BW),
        .BOX_H     (BH),
        .BG_COLOUR (3'b000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .space_pressed (space_pressed),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pixel i of a raster is visible one step after the state's i-th cycle.
    task automatic check_raster(input string tag, input int x0, input int y0,
                                input logic [2:0] col, input int npix,
                                input int done_at, output int nplot);
        int   px;
        int   py;
        logic exp_plot;
        nplot = 0;
        for (int i = 0; i < npix; i++) begin
            step();
            px       = x0 + (i % BW);
            py       = y0 + (i / BW);
            exp_plot = (px <= 159) && (py <= 119);
            check_value({tag, "_plot"}, bus.plot, exp_plot);
            if (exp_plot) begin
                check_value({tag, "_x"}, bus.vga_x, px);
                check_value({tag, "_y"}, bus.vga_y, py);
                check_value({tag, "_col"}, bus.vga_colour, col);
            end
            if (bus.plot) nplot++;
            if ((done_at >= 0) && (i == done_at + 1))
                check_value({tag, "_upd_low"}, bus.update_enemy, 0);
            bus.done_update_enemy = (i == done_at);
        end
        bus.done_update_enemy = 1'b0;
    endtask

    task automatic pulse_done(input int new_x);
        bus.enemy_x           = new_x[7:0];
        bus.done_update_enemy = 1'b1;
        step();
        bus.done_update_enemy = 1'b0;
        check_value("req_fall", bus.update_enemy, 0);
    endtask

    task automatic latch_gap();
        step();
        check_value("latch_idle", bus.plot, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_plot"}, bus.plot, 0);
        check_value({tag, "_upd"}, bus.update_enemy, 0);
        check_value({tag, "_x"}, bus.vga_x, 0);
        check_value({tag, "_y"}, bus.vga_y, 0);
        check_value({tag, "_col"}, bus.vga_colour, 0);
    endtask

    initial begin
        n_checks              = 0;
        n_fail                = 0;
        reset                 = 1'b0;
        space_pressed         = 1'b0;
        bus.done_update_enemy = 1'b0;
        bus.enemy_x           = 8'd130;
        bus.enemy_y           = 7'd85;
        bus.enemy_colour      = 3'b100;

        #12;
        check_all_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // First box after reset
        step();
        check_value("init_idle", bus.plot, 0);
        check_raster("draw0", 130, 85, 3'b100, 16, -1, n);
        check_value("draw0_count", n, 16);
        check_value("req_rise", bus.update_enemy, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("req_hold", bus.update_enemy, 1);
            check_value("req_noplot", bus.plot, 0);
        end

        // Handshake, erase old, draw new; spurious done during the draw
        pulse_done(129);
        check_raster("erase0", 130, 85, 3'b000, 16, -1, n);
        latch_gap();
        check_raster("draw1", 129, 85, 3'b100, 16, 4, n);
        check_value("req_after_spur", bus.update_enemy, 1);

        // Right-edge clipping
        pulse_done(158);
        check_raster("erase1", 129, 85, 3'b000, 16, -1, n);
        latch_gap();
        check_raster("clip", 158, 85, 3'b100, 16, -1, n);
        check_value("clip_count", n, 8);
        check_value("clip_req", bus.update_enemy, 1);

        pulse_done(100);
        check_raster("erase2", 158, 85, 3'b000, 16, -1, n);
        check_value("erase2_count", n, 8);
        latch_gap();

        // Restart mid-draw, key held throughout the recovery
        check_raster("draw3", 100, 85, 3'b100, 7, -1, n);
        space_pressed = 1'b1;
        bus.enemy_x   = 8'd130;
        step();
        check_value("restart_plot", bus.plot, 1);
        check_value("restart_x", bus.vga_x, 103);
        check_value("restart_y", bus.vga_y, 86);
        check_value("restart_upd", bus.update_enemy, 0);
        check_raster("erase3", 100, 85, 3'b000, 16, -1, n);
        latch_gap();
        check_raster("rehome", 130, 85, 3'b100, 16, -1, n);
        space_pressed = 1'b0;
        check_value("rehome_req", bus.update_enemy, 1);

        // Asynchronous reset in the middle of an erase
        pulse_done(120);
        check_raster("erase4", 130, 85, 3'b000, 7, -1, n);
        reset = 1'b0;
        #1;
        check_all_zero("async");
        @(posedge clk);
        #1;
        check_all_zero("async_hold");
        reset = 1'b1;
        step();
        check_value("init_idle2", bus.plot, 0);
        check_raster("draw5", 120, 85, 3'b100, 16, -1, n);
        check_value("draw5_req", bus.update_enemy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
